// File: rtl/ddr_eng_pkg.sv
// Shared definitions for the DDR AXI burst engine: FSM state encoding,
// command opcodes, AXI field constants and the 4 KB boundary check.
package ddr_eng_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ADDR,
    S_WDATA,
    S_WRESP,
    S_RDATA,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_VERIFY  = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam logic ATYPE_RD = 1'b0;
  localparam logic ATYPE_WR = 1'b1;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] LOCK_NORMAL = 2'b00;

  localparam int unsigned BOUNDARY_4K = 4096;

  // True when a burst of (len+1) beats of 'bytes' bytes starting at page
  // offset 'offs' would run past the end of its 4 KB page.
  function automatic logic crosses_4k(input logic [11:0] offs,
                                      input logic [7:0]  len,
                                      input int unsigned bytes);
    logic [23:0] w_end;
    w_end = 24'(offs) + (24'(len) + 24'd1) * 24'(bytes);
    return (w_end > 24'(BOUNDARY_4K));
  endfunction

endpackage

// File: rtl/ddr_beat_cmp.sv
// Verify-mode comparator with a saturating mismatch counter.
// Ports:
//   i_clk, i_rst_n   clock and synchronous active-low reset
//   i_clr            clears the counter (a verify command was accepted)
//   i_beat           a read beat is being consumed this cycle
//   i_act, i_exp     data read from DDR and the expected data
//   o_err_cnt        mismatch count, sticks at all ones
module ddr_beat_cmp #(
  parameter int DATA_W = 256,
  parameter int ERR_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_beat,
  input  logic [DATA_W-1:0] i_act,
  input  logic [DATA_W-1:0] i_exp,
  output logic [ERR_W-1:0]  o_err_cnt
);

  logic [ERR_W-1:0] r_err_cnt;
  logic             w_mismatch;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign w_mismatch = (i_act != i_exp);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_err_cnt <= '0;
    end else if (i_clr) begin
      r_err_cnt <= '0;
    end else if (i_beat && w_mismatch) begin
      r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

  assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/ddr_burst_engine.sv
// AXI4 burst engine on the DDR controller's shared-address port 0.
// Turns one write/read/verify command into a single INCR burst.
// Ports:
//   axi_clk, rst_n              clock, synchronous active-low reset
//   cmd_*                       command handshake (op, byte addr, beats-1)
//   wr_*                        write stream; expected data in verify mode
//   rd_*                        read stream
//   busy/done/cmd_err           status; done and cmd_err are 1-cycle pulses
//   resp_err                    sticky bad-RRESP / RLAST-mismatch flag
//   err_cnt                     saturating verify mismatch count
//   DdrCtrl_A*_0                shared read/write address channel (ATYPE)
//   DdrCtrl_W*_0, R*_0, B*_0    write data, read data, write response
module ddr_burst_engine
  import ddr_eng_pkg::*;
#(
  parameter int         DATA_W  = 256,
  parameter int         ADDR_W  = 32,
  parameter int         MAX_LEN = 255,
  parameter logic [7:0] AXI_ID  = 8'h00,
  parameter int         ERR_W   = 16
) (
  input  logic                axi_clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                busy,
  output logic                done,
  output logic                cmd_err,
  output logic                resp_err,
  output logic [ERR_W-1:0]    err_cnt,
  output logic [7:0]          DdrCtrl_AID_0,
  output logic [ADDR_W-1:0]   DdrCtrl_AADDR_0,
  output logic [7:0]          DdrCtrl_ALEN_0,
  output logic [2:0]          DdrCtrl_ASIZE_0,
  output logic [1:0]          DdrCtrl_ABURST_0,
  output logic [1:0]          DdrCtrl_ALOCK_0,
  output logic                DdrCtrl_AVALID_0,
  output logic                DdrCtrl_ATYPE_0,
  input  logic                DdrCtrl_AREADY_0,
  output logic [7:0]          DdrCtrl_WID_0,
  output logic [DATA_W-1:0]   DdrCtrl_WDATA_0,
  output logic [DATA_W/8-1:0] DdrCtrl_WSTRB_0,
  output logic                DdrCtrl_WLAST_0,
  output logic                DdrCtrl_WVALID_0,
  input  logic                DdrCtrl_WREADY_0,
  input  logic [7:0]          DdrCtrl_RID_0,
  input  logic [DATA_W-1:0]   DdrCtrl_RDATA_0,
  input  logic                DdrCtrl_RLAST_0,
  input  logic                DdrCtrl_RVALID_0,
  input  logic [1:0]          DdrCtrl_RRESP_0,
  output logic                DdrCtrl_RREADY_0,
  input  logic [7:0]          DdrCtrl_BID_0,
  input  logic                DdrCtrl_BVALID_0,
  output logic                DdrCtrl_BREADY_0
);

  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = $clog2(BYTES);

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_beat;
  logic              r_resp_err;

  logic w_cmd_ready;
  logic w_accept;
  logic w_illegal;
  logic w_last_beat;
  logic w_in_addr;
  logic w_in_wdata;
  logic w_verify;
  logic w_wbeat;
  logic w_rbeat;
  logic w_unused_ok;

  // IDs are fixed; low address bits below the beat size are dropped.
  assign w_unused_ok = ^{DdrCtrl_RID_0, DdrCtrl_BID_0, cmd_addr[LSB-1:0]};

  assign w_accept    = (r_state == S_IDLE) && cmd_valid && rst_n;
  assign w_last_beat = (r_beat == r_len);
  assign w_in_addr   = (r_state == S_ADDR);
  assign w_in_wdata  = (r_state == S_WDATA);
  assign w_verify    = (r_op == OP_VERIFY);
  assign w_illegal   = (r_op == OP_ILLEGAL) || (32'(r_len) > MAX_LEN) ||
                       crosses_4k(r_addr[11:0], r_len, BYTES);
  assign w_wbeat     = w_in_wdata && wr_valid && DdrCtrl_WREADY_0;
  assign w_rbeat     = (r_state == S_RDATA) && DdrCtrl_RVALID_0 && DdrCtrl_RREADY_0;

  // state register
  always_ff @(posedge axi_clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next state and handshake outputs
  always_comb begin
    w_state_nxt      = r_state;
    w_cmd_ready      = 1'b0;
    DdrCtrl_AVALID_0 = 1'b0;
    DdrCtrl_WVALID_0 = 1'b0;
    DdrCtrl_BREADY_0 = 1'b0;
    DdrCtrl_RREADY_0 = 1'b0;
    wr_ready         = 1'b0;
    rd_valid         = 1'b0;
    done             = 1'b0;
    cmd_err          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_illegal) begin
          cmd_err     = 1'b1;
          done        = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        DdrCtrl_AVALID_0 = 1'b1;
        if (DdrCtrl_AREADY_0) w_state_nxt = (r_op == OP_WRITE) ? S_WDATA : S_RDATA;
      end
      S_WDATA: begin
        DdrCtrl_WVALID_0 = wr_valid;
        wr_ready         = DdrCtrl_WREADY_0;
        if (wr_valid && DdrCtrl_WREADY_0 && w_last_beat) w_state_nxt = S_WRESP;
      end
      S_WRESP: begin
        DdrCtrl_BREADY_0 = 1'b1;
        if (DdrCtrl_BVALID_0) w_state_nxt = S_DONE;
      end
      S_RDATA: begin
        // In verify mode the expected stream paces the read channel and
        // the two streams handshake together.
        if (w_verify) begin
          DdrCtrl_RREADY_0 = wr_valid;
          wr_ready         = DdrCtrl_RVALID_0;
        end else begin
          DdrCtrl_RREADY_0 = rd_ready;
          rd_valid         = DdrCtrl_RVALID_0;
        end
        // The internal beat count ends the burst, not RLAST.
        if (DdrCtrl_RVALID_0 && DdrCtrl_RREADY_0 && w_last_beat) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // command control and beat counting
  always_ff @(posedge axi_clk) begin
    if (!rst_n) begin
      r_op       <= OP_WRITE;
      r_beat     <= '0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= cmd_op;
        r_beat <= '0;
      end else if (w_wbeat || w_rbeat) begin
        r_beat <= r_beat + 8'd1;
      end
      if (w_rbeat && ((DdrCtrl_RRESP_0 != 2'b00) || (DdrCtrl_RLAST_0 != w_last_beat)))
        r_resp_err <= 1'b1;
    end
  end

  // command payload; only observed while the FSM is past IDLE
  always_ff @(posedge axi_clk) begin
    if (w_accept) begin
      r_addr <= {cmd_addr[ADDR_W-1:LSB], {LSB{1'b0}}};
      r_len  <= cmd_len;
    end
  end

  ddr_beat_cmp #(
    .DATA_W (DATA_W),
    .ERR_W  (ERR_W)
  ) u_cmp (
    .i_clk     (axi_clk),
    .i_rst_n   (rst_n),
    .i_clr     (w_accept && (cmd_op == OP_VERIFY)),
    .i_beat    (w_rbeat && w_verify),
    .i_act     (DdrCtrl_RDATA_0),
    .i_exp     (wr_data),
    .o_err_cnt (err_cnt)
  );

  // Address fields read zero outside the address phase so every output
  // is quiet in IDLE.
  assign cmd_ready        = w_cmd_ready && rst_n;
  assign busy             = (r_state != S_IDLE);
  assign resp_err         = r_resp_err;
  assign DdrCtrl_AID_0    = AXI_ID;
  assign DdrCtrl_WID_0    = AXI_ID;
  assign DdrCtrl_AADDR_0  = w_in_addr ? r_addr : '0;
  assign DdrCtrl_ALEN_0   = w_in_addr ? r_len : 8'd0;
  assign DdrCtrl_ASIZE_0  = w_in_addr ? 3'(LSB) : 3'd0;
  assign DdrCtrl_ABURST_0 = w_in_addr ? BURST_INCR : 2'b00;
  assign DdrCtrl_ALOCK_0  = LOCK_NORMAL;
  assign DdrCtrl_ATYPE_0  = w_in_addr && (r_op == OP_WRITE) ? ATYPE_WR : ATYPE_RD;
  assign DdrCtrl_WDATA_0  = w_in_wdata ? wr_data : '0;
  assign DdrCtrl_WSTRB_0  = w_in_wdata ? '1 : '0;
  assign DdrCtrl_WLAST_0  = w_in_wdata && w_last_beat;
  assign rd_data          = ((r_state == S_RDATA) && !w_verify) ? DdrCtrl_RDATA_0 : '0;

endmodule

// File: tb/tb_ddr_burst_engine.sv
module tb_ddr_burst_engine;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 32;
  localparam int ERR_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic              wr_valid, wr_ready, rd_valid, rd_ready;
  logic              busy, done, cmd_err, resp_err;
  logic [ERR_W-1:0]  err_cnt;
  logic [7:0]        aid, alen, wid;
  logic [ADDR_W-1:0] aaddr;
  logic [2:0]        asize;
  logic [1:0]        aburst, alock, rresp;
  logic              avalid, atype, aready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [31:0]       wstrb;
  logic              wlast, wvalid, wready, rlast, rvalid, rready, bvalid, bready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ddr_burst_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_LEN(100), .AXI_ID(8'h5A), .ERR_W(ERR_W)
  ) dut (
    .axi_clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .cmd_err(cmd_err), .resp_err(resp_err), .err_cnt(err_cnt),
    .DdrCtrl_AID_0(aid), .DdrCtrl_AADDR_0(aaddr), .DdrCtrl_ALEN_0(alen),
    .DdrCtrl_ASIZE_0(asize), .DdrCtrl_ABURST_0(aburst), .DdrCtrl_ALOCK_0(alock),
    .DdrCtrl_AVALID_0(avalid), .DdrCtrl_ATYPE_0(atype), .DdrCtrl_AREADY_0(aready),
    .DdrCtrl_WID_0(wid), .DdrCtrl_WDATA_0(wdata), .DdrCtrl_WSTRB_0(wstrb),
    .DdrCtrl_WLAST_0(wlast), .DdrCtrl_WVALID_0(wvalid), .DdrCtrl_WREADY_0(wready),
    .DdrCtrl_RID_0(8'h5A), .DdrCtrl_RDATA_0(rdata), .DdrCtrl_RLAST_0(rlast),
    .DdrCtrl_RVALID_0(rvalid), .DdrCtrl_RRESP_0(rresp), .DdrCtrl_RREADY_0(rready),
    .DdrCtrl_BID_0(8'h5A), .DdrCtrl_BVALID_0(bvalid), .DdrCtrl_BREADY_0(bready)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] wpat(input int k);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(k);
    return {8{w}};
  endfunction

  function automatic logic [255:0] rpat(input int k);
    logic [31:0] w;
    w = 32'h1234_0000 + 32'(k);
    return {8{w}};
  endfunction

  function automatic logic [255:0] vpat(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(k * 3);
    return {8{w}};
  endfunction

  // Presents a command in IDLE, lets it be accepted, and checks the CHECK cycle.
  task automatic issue(input logic [1:0] op, input logic [31:0] addr,
                       input logic [7:0] len, input logic exp_ill);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len;
    #1;
    check("cmd_ready_idle", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    #1;
    check("busy_check", busy, 1'b1);
    check("cmd_ready_busy", cmd_ready, 1'b0);
    check("cmd_err_check", cmd_err, exp_ill);
    check("done_check", done, exp_ill);
    check("avalid_check", avalid, 1'b0);
  endtask

  task automatic write_burst(input logic [31:0] addr, input int len, input int stall_beat);
    int beats;
    int cyc;
    logic stalled;
    beats = 0; cyc = 0; stalled = 1'b0;
    issue(2'b00, addr, 8'(len), 1'b0);
    step();
    check("wr_avalid", avalid, 1'b1);
    check("wr_atype", atype, 1'b1);
    check("wr_aaddr", aaddr, addr);
    check("wr_alen", alen, 8'(len));
    check("wr_asize", asize, 3'd5);
    check("wr_aburst", aburst, 2'b01);
    aready = 1'b1;
    step();
    aready = 1'b0;
    while (beats <= len && cyc < 100) begin
      wr_valid = 1'b1;
      wr_data  = wpat(beats);
      wready   = !((beats == stall_beat) && !stalled);
      #1;
      check("wr_wvalid", wvalid, 1'b1);
      check("wr_wdata", wdata, wpat(beats));
      check("wr_wstrb", wstrb, 32'hFFFF_FFFF);
      check("wr_wlast", wlast, (beats == len) && wready);
      check("wr_ready", wr_ready, wready);
      if (wready) beats++;
      else stalled = 1'b1;
      step();
      cyc++;
    end
    wr_valid = 1'b0; wready = 1'b0;
    #1;
    check("wr_bound", cyc < 100, 1'b1);
    check("wr_bready", bready, 1'b1);
    check("wr_wvalid_off", wvalid, 1'b0);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    check("wr_done", done, 1'b1);
    step();
    check("wr_done_end", done, 1'b0);
    check("wr_busy_end", busy, 1'b0);
  endtask

  task automatic verify_burst(input int len, input logic all_bad, input int bad_idx,
                              input logic rlast_en);
    int k;
    int cyc;
    logic gapped;
    logic gap;
    k = 0; cyc = 0; gapped = 1'b0;
    issue(2'b10, 32'h3000, 8'(len), 1'b0);
    check("vf_err_clr", err_cnt, 4'd0);
    step();
    check("vf_atype", atype, 1'b0);
    aready = 1'b1;
    step();
    aready = 1'b0;
    while (k <= len && cyc < 200) begin
      gap      = (k == 1) && !gapped;
      rvalid   = 1'b1;
      rdata    = vpat(k);
      rlast    = rlast_en && (k == len);
      wr_valid = !gap;
      wr_data  = (all_bad || k == bad_idx) ? ~vpat(k) : vpat(k);
      #1;
      check("vf_rd_valid", rd_valid, 1'b0);
      check("vf_rready", rready, !gap);
      check("vf_wr_ready", wr_ready, 1'b1);
      if (!gap) k++;
      else gapped = 1'b1;
      step();
      cyc++;
    end
    rvalid = 1'b0; rlast = 1'b0; wr_valid = 1'b0;
    #1;
    check("vf_bound", cyc < 200, 1'b1);
    check("vf_done", done, 1'b1);
    step();
    check("vf_busy_end", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cyc;
    logic rdr;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0; aready = 1'b0; wready = 1'b0;
    rdata = '0; rlast = 1'b0; rvalid = 1'b0; rresp = 2'b00; bvalid = 1'b0;
    step(); step();
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_avalid", avalid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_err_cnt", err_cnt, 4'd0);
    check("rst_aid", aid, 8'h5A);
    check("rst_wid", wid, 8'h5A);
    check("rst_aaddr", aaddr, 32'h0);
    rst_n = 1'b1;
    step();

    // write, len 7, one stalled beat
    write_burst(32'h1000, 7, 2);
    // ends exactly on the 4 KB page boundary: legal
    write_burst(32'h0FC0, 1, 9);

    // read, unaligned address, rd_ready toggling
    issue(2'b01, 32'h2013, 8'd3, 1'b0);
    step();
    check("rd_atype", atype, 1'b0);
    check("rd_aaddr", aaddr, 32'h2000);
    check("rd_alen", alen, 8'd3);
    aready = 1'b1;
    step();
    aready = 1'b0;
    k = 0; cyc = 0; rdr = 1'b1;
    while (k <= 3 && cyc < 20) begin
      rd_ready = rdr; rvalid = 1'b1; rdata = rpat(k); rlast = (k == 3);
      #1;
      check("rd_rready", rready, rdr);
      check("rd_valid", rd_valid, 1'b1);
      check("rd_data", rd_data, rpat(k));
      if (rdr) k++;
      rdr = !rdr;
      step();
      cyc++;
    end
    rvalid = 1'b0; rlast = 1'b0; rd_ready = 1'b0;
    #1;
    check("rd_bound", cyc < 20, 1'b1);
    check("rd_done", done, 1'b1);
    step();
    check("rd_busy_end", busy, 1'b0);
    check("rd_resp_err", resp_err, 1'b0);

    // verify, len 7, beat 3 wrong
    verify_burst(7, 1'b0, 3, 1'b1);
    check("vf_err_cnt", err_cnt, 4'd1);
    check("vf_resp_err", resp_err, 1'b0);

    // illegal commands
    issue(2'b00, 32'h0FE0, 8'd1, 1'b1);
    step();
    check("ill4k_avalid", avalid, 1'b0);
    check("ill4k_busy", busy, 1'b0);
    check("ill4k_cmd_err_end", cmd_err, 1'b0);
    issue(2'b11, 32'h0000, 8'd0, 1'b1);
    step();
    check("illop_avalid", avalid, 1'b0);
    check("illop_busy", busy, 1'b0);
    issue(2'b01, 32'h0000, 8'd101, 1'b1);
    step();
    check("illlen_avalid", avalid, 1'b0);
    check("illlen_busy", busy, 1'b0);
    check("ill_err_cnt_kept", err_cnt, 4'd1);

    // reset during beat 4 of an 8-beat write
    issue(2'b00, 32'h4000, 8'd7, 1'b0);
    step();
    aready = 1'b1;
    step();
    aready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      wr_valid = 1'b1; wr_data = wpat(b); wready = 1'b1;
      step();
    end
    rst_n = 1'b0;
    #1;
    check("mid_wvalid_pre", wvalid, 1'b1);
    step();
    check("mid_wvalid", wvalid, 1'b0);
    check("mid_avalid", avalid, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_wr_ready", wr_ready, 1'b0);
    rst_n = 1'b1; wr_valid = 1'b0; wready = 1'b0;
    #1;
    check("mid_cmd_ready", cmd_ready, 1'b1);
    check("mid_err_cnt", err_cnt, 4'd0);
    write_burst(32'h4000, 7, 9);

    // saturation, and RLAST never arrives
    verify_burst(1, 1'b0, 0, 1'b1);
    check("pre_sat_err_cnt", err_cnt, 4'd1);
    verify_burst(31, 1'b1, 0, 1'b0);
    check("sat_err_cnt", err_cnt, 4'd15);
    check("sat_resp_err", resp_err, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
